// File: rtl/m68k_dtack_gen_if.sv
// Bus-cycle handshake bundle between the 68000 address decode and the DTACK/BERR generator.
// The master side is the CPU, decode, SDRAM and video arbiter environment.
interface m68k_dtack_gen_if;
    logic as_n;
    logic rw;
    logic fast_cs;
    logic rom_cs;
    logic vid_cs;
    logic sdram_ready;
    logic vid_grant;
    logic dtack_n;
    logic berr_n;
    logic sdram_req;
    logic vid_req;
    logic timeout_flag;

    modport master (
        output as_n, rw, fast_cs, rom_cs, vid_cs, sdram_ready, vid_grant,
        input  dtack_n, berr_n, sdram_req, vid_req, timeout_flag
    );

    modport slave (
        input  as_n, rw, fast_cs, rom_cs, vid_cs, sdram_ready, vid_grant,
        output dtack_n, berr_n, sdram_req, vid_req, timeout_flag
    );
endinterface

// File: rtl/m68k_dtack_gen.sv
// DTACK/BERR generator for a 68000 bus: fast fixed-latency accesses, SDRAM ROM reads
// and arbitrated video RAM accesses, with a wait-state watchdog raising bus error.
module m68k_dtack_gen #(
    parameter int unsigned FAST_WAIT = 0,
    parameter int unsigned TIMEOUT   = 1023
) (
    input logic             clk,
    input logic             reset_n,
    m68k_dtack_gen_if.slave bus
);
    localparam int unsigned CNT_W = 10;
    localparam int unsigned FW_W  = 4;
    localparam logic [FW_W-1:0]  FW_LOAD = FW_W'(FAST_WAIT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_FAST_WAIT,
        ST_SDRAM_WAIT,
        ST_VID_WAIT,
        ST_ACK,
        ST_BERR
    } state_e;

    state_e           state_q, state_d;
    logic [FW_W-1:0]  fw_cnt_q, fw_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             dtack_n_q, dtack_n_d;
    logic             berr_n_q, berr_n_d;
    logic             sdram_req_q, sdram_req_d;
    logic             vid_req_q, vid_req_d;
    logic             timeout_q, timeout_d;

    // Next-state logic; an address strobe release in any pre-acknowledge state aborts the cycle.
    always_comb begin
        state_d    = state_q;
        fw_cnt_d   = fw_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus.as_n) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                wait_cnt_d = '0;
                if (bus.as_n) begin
                    state_d = ST_IDLE;
                end else if (bus.rom_cs && bus.rw) begin
                    state_d = ST_SDRAM_WAIT;
                end else if (!bus.rom_cs && bus.vid_cs) begin
                    state_d = ST_VID_WAIT;
                end else if (FAST_WAIT == 0) begin
                    state_d = ST_ACK;
                end else begin
                    state_d  = ST_FAST_WAIT;
                    fw_cnt_d = FW_LOAD;
                end
            end
            ST_FAST_WAIT: begin
                fw_cnt_d = fw_cnt_q - FW_W'(1);
                if (bus.as_n)               state_d = ST_IDLE;
                else if (fw_cnt_q == FW_W'(1)) state_d = ST_ACK;
            end
            ST_SDRAM_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (bus.as_n)                 state_d = ST_IDLE;
                else if (bus.sdram_ready)     state_d = ST_ACK;
                else if (wait_cnt_q == TO_LAST) state_d = ST_BERR;
            end
            ST_VID_WAIT: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                if (bus.as_n)                 state_d = ST_IDLE;
                else if (bus.vid_grant)       state_d = ST_ACK;
                else if (wait_cnt_q == TO_LAST) state_d = ST_BERR;
            end
            ST_ACK: begin
                if (bus.as_n) state_d = ST_IDLE;
            end
            ST_BERR: begin
                if (bus.as_n) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they change on the same edge.
        dtack_n_d   = (state_d != ST_ACK);
        berr_n_d    = (state_d != ST_BERR);
        sdram_req_d = (state_d == ST_SDRAM_WAIT);
        vid_req_d   = (state_d == ST_VID_WAIT);
        if (state_d == ST_BERR) timeout_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            fw_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
            sdram_req_q <= 1'b0;
            vid_req_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fw_cnt_q    <= fw_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            dtack_n_q   <= dtack_n_d;
            berr_n_q    <= berr_n_d;
            sdram_req_q <= sdram_req_d;
            vid_req_q   <= vid_req_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.dtack_n      = dtack_n_q;
    assign bus.berr_n       = berr_n_q;
    assign bus.sdram_req    = sdram_req_q;
    assign bus.vid_req      = vid_req_q;
    assign bus.timeout_flag = timeout_q;
endmodule

// File: tb/tb_m68k_dtack_gen.sv
// Bench for m68k_dtack_gen: two instances with different wait parameters share one
// stimulus stream; outputs are compared against a transaction-level timing model.
module tb_m68k_dtack_gen;
    localparam int FW0   = 0;
    localparam int TO0   = 8;
    localparam int FW1   = 3;
    localparam int TO1   = 5;
    localparam int NEVER = 1000;
    localparam int MAXK  = 64;
    localparam int ND    = 9;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic as_n = 1'b1, rw = 1'b1, fast_cs = 1'b0, rom_cs = 1'b0, vid_cs = 1'b0;
    logic sdram_ready = 1'b0, vid_grant = 1'b0;

    always #5 clk = ~clk;

    m68k_dtack_gen_if bus0();
    m68k_dtack_gen_if bus1();

    assign bus0.as_n = as_n;         assign bus1.as_n = as_n;
    assign bus0.rw = rw;             assign bus1.rw = rw;
    assign bus0.fast_cs = fast_cs;   assign bus1.fast_cs = fast_cs;
    assign bus0.rom_cs = rom_cs;     assign bus1.rom_cs = rom_cs;
    assign bus0.vid_cs = vid_cs;     assign bus1.vid_cs = vid_cs;
    assign bus0.sdram_ready = sdram_ready; assign bus1.sdram_ready = sdram_ready;
    assign bus0.vid_grant = vid_grant;     assign bus1.vid_grant = vid_grant;

    m68k_dtack_gen #(.FAST_WAIT(FW0), .TIMEOUT(TO0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    m68k_dtack_gen #(.FAST_WAIT(FW1), .TIMEOUT(TO1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    int total = 0;
    int bad = 0;
    bit flag_m [2];
    logic [4:0] obs [2][MAXK];

    // Directed table: sel = {rom_cs, vid_cs, fast_cs, rw}; r = first edge (from E0) sampling
    // ready/grant high; l = edge sampling as_n high; g = extra idle edges afterwards.
    logic [3:0] d_sel [ND] = '{4'b0011, 4'b1001, 4'b0101, 4'b1001, 4'b1110,
                               4'b1001, 4'b0101, 4'b0000, 4'b1101};
    int d_r [ND] = '{NEVER, 6, NEVER, NEVER, 3, 2, 9, NEVER, 4};
    int d_l [ND] = '{5, 9, 12, 4, 7, 4, 11, 6, 7};
    int d_g [ND] = '{1, 1, 1, 2, 1, 0, 1, 1, 1};

    // 0 = fast/open bus/ROM write, 1 = SDRAM read, 2 = video access.
    function automatic int txn_kind(input bit rom, input bit vid, input bit rd);
        if (rom && rd) return 1;
        if (!rom && vid) return 2;
        return 0;
    endfunction

    // Edge (counted from E0) at which the access resolves, and whether it resolves as a bus error.
    function automatic int comp_edge(input int d, input int kind, input int r, output bit berr);
        int fw;
        int to;
        fw = (d == 0) ? FW0 : FW1;
        to = (d == 0) ? TO0 : TO1;
        berr = 1'b0;
        if (kind == 0) return 1 + fw;
        if (r <= 1 + to) return r;
        berr = 1'b1;
        return 1 + to;
    endfunction

    // Expected {dtack_n, berr_n, sdram_req, vid_req, timeout_flag} right after edge k.
    function automatic logic [4:0] exp_vec(input int d, input int kind, input int r,
                                           input int l, input int k);
        bit berr;
        bit done;
        int a;
        int e;
        a = comp_edge(d, kind, r, berr);
        done = (l > a);
        e = done ? a : l;
        return {!(done && !berr && k >= a && k < l),
                !(done && berr && k >= a && k < l),
                (kind == 1 && k >= 1 && k < e),
                (kind == 2 && k >= 1 && k < e),
                (flag_m[d] || (done && berr && k >= a))};
    endfunction

    task automatic run_txn(input bit rom, input bit vid, input bit fcs, input bit rw_i,
                           input int r, input int l, input int g, output int n);
        int kind;
        kind = txn_kind(rom, vid, rw_i);
        n = l + g + 1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            as_n    = (k < l) ? 1'b0 : 1'b1;
            rom_cs  = rom;
            vid_cs  = vid;
            fast_cs = fcs;
            rw      = rw_i;
            if (kind == 1) sdram_ready = (k >= r);
            else           sdram_ready = 1'($urandom % 2);
            if (kind == 2) vid_grant = (k >= r);
            else           vid_grant = 1'($urandom % 2);
            @(posedge clk);
            #1;
            obs[0][k] = {bus0.dtack_n, bus0.berr_n, bus0.sdram_req, bus0.vid_req, bus0.timeout_flag};
            obs[1][k] = {bus1.dtack_n, bus1.berr_n, bus1.sdram_req, bus1.vid_req, bus1.timeout_flag};
        end
    endtask

    task automatic finish_txn(input int kind, input int r, input int l, input int n);
        logic [4:0] v;
        for (int d = 0; d < 2; d++) begin
            v = exp_vec(d, kind, r, l, n - 1);
            flag_m[d] = v[0];
        end
    endtask

    task automatic test_reset();
        logic [4:0] v0, v1;
        as_n = 1'b0;
        rom_cs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        v0 = {bus0.dtack_n, bus0.berr_n, bus0.sdram_req, bus0.vid_req, bus0.timeout_flag};
        v1 = {bus1.dtack_n, bus1.berr_n, bus1.sdram_req, bus1.vid_req, bus1.timeout_flag};
        total++;
        if (v0 !== 5'b11000) begin bad++; $display("FAIL reset_hold dut0 got=%b exp=11000", v0); end
        total++;
        if (v1 !== 5'b11000) begin bad++; $display("FAIL reset_hold dut1 got=%b exp=11000", v1); end
        as_n = 1'b1;
        rom_cs = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        v0 = {bus0.dtack_n, bus0.berr_n, bus0.sdram_req, bus0.vid_req, bus0.timeout_flag};
        total++;
        if (v0 !== 5'b11000) begin bad++; $display("FAIL reset_release dut0 got=%b exp=11000", v0); end
        flag_m[0] = 1'b0;
        flag_m[1] = 1'b0;
    endtask

    task automatic test_directed();
        int n;
        int kind;
        logic [4:0] ev;
        for (int i = 0; i < ND; i++) begin
            kind = txn_kind(d_sel[i][3], d_sel[i][2], d_sel[i][0]);
            run_txn(d_sel[i][3], d_sel[i][2], d_sel[i][1], d_sel[i][0], d_r[i], d_l[i], d_g[i], n);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < n; k++) begin
                    ev = exp_vec(d, kind, d_r[i], d_l[i], k);
                    total++;
                    if (obs[d][k] !== ev) begin
                        bad++;
                        $display("FAIL directed%0d dut%0d k=%0d got=%b exp=%b", i, d, k, obs[d][k], ev);
                    end
                end
            end
            finish_txn(kind, d_r[i], d_l[i], n);
        end
    endtask

    task automatic test_random(input int count, input bit b2b);
        int n, kind, r, l, g, a0, a1, amax;
        bit rom, vid, fcs, rd, be;
        logic [4:0] ev;
        for (int i = 0; i < count; i++) begin
            {rom, vid, fcs, rd} = 4'($urandom);
            kind = txn_kind(rom, vid, rd);
            r = ($urandom % 5 == 0) ? NEVER : 2 + int'($urandom % 10);
            a0 = comp_edge(0, kind, r, be);
            a1 = comp_edge(1, kind, r, be);
            amax = (a0 > a1) ? a0 : a1;
            if (!b2b && ($urandom % 5 == 0)) l = 1 + int'($urandom % amax);
            else l = amax + 1 + int'($urandom % 3);
            g = b2b ? 0 : int'($urandom % 3);
            run_txn(rom, vid, fcs, rd, r, l, g, n);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < n; k++) begin
                    ev = exp_vec(d, kind, r, l, k);
                    total++;
                    if (obs[d][k] !== ev) begin
                        bad++;
                        $display("FAIL %s%0d dut%0d sel=%b%b%b%b r=%0d l=%0d k=%0d got=%b exp=%b",
                                 b2b ? "b2b" : "random", i, d, rom, vid, fcs, rd, r, l, k,
                                 obs[d][k], ev);
                    end
                end
            end
            finish_txn(kind, r, l, n);
        end
    endtask

    task automatic test_reset_mid_vid();
        int n;
        logic [4:0] ev, v0, v1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            as_n = 1'b0; vid_cs = 1'b1; rom_cs = 1'b0; fast_cs = 1'b0; rw = 1'b1;
            vid_grant = 1'b0; sdram_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        total++;
        if ({bus0.vid_req, bus1.vid_req} !== 2'b11) begin
            bad++;
            $display("FAIL vid_req_before_reset got=%b%b exp=11", bus0.vid_req, bus1.vid_req);
        end
        #2 reset_n = 1'b0;
        #1;
        v0 = {bus0.dtack_n, bus0.berr_n, bus0.sdram_req, bus0.vid_req, bus0.timeout_flag};
        v1 = {bus1.dtack_n, bus1.berr_n, bus1.sdram_req, bus1.vid_req, bus1.timeout_flag};
        total++;
        if (v0 !== 5'b11000) begin bad++; $display("FAIL async_reset dut0 got=%b exp=11000", v0); end
        total++;
        if (v1 !== 5'b11000) begin bad++; $display("FAIL async_reset dut1 got=%b exp=11000", v1); end
        flag_m[0] = 1'b0;
        flag_m[1] = 1'b0;
        as_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 4, 7, 1, n);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < n; k++) begin
                ev = exp_vec(d, 2, 4, 7, k);
                total++;
                if (obs[d][k] !== ev) begin
                    bad++;
                    $display("FAIL after_reset dut%0d k=%0d got=%b exp=%b", d, k, obs[d][k], ev);
                end
            end
        end
        finish_txn(2, 4, 7, n);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(40, 1'b0);
        test_random(12, 1'b1);
        test_reset_mid_vid();
        test_random(10, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
